wu_memory: RTL and testbench
============================

# wu_memory

Responder side of the WU fetch interface inside the manager. It holds the work-unit (WU) instruction store, which the system loads through a write port. It services the fetcher's read/address stream with a fixed 1-cycle array read, buffers returned words in an output FIFO toward the WU decoder, and raises `wum__wuf__stall` early enough to absorb the reads the fetcher already has in flight.

## Interface
Parameters:
- `WU_DATA_WIDTH`, default 64: WU instruction word width.
- `WU_DEPTH`, default 1024: number of words in the store; at most 2^width of `MGR_WU_ADDRESS_RANGE`.
- `FIFO_DEPTH`, default 8: output FIFO entries, power of 2.
- `STALL_SKID`, default 4: headroom reserved for reads issued after stall is raised.

Ports:
- `clk` in 1: single clock.
- `reset_poweron` in 1: reset, synchronous, active-high.
- `wuf__wum__read` in 1: read request, one word per asserted cycle.
- `wuf__wum__addr` in `MGR_WU_ADDRESS_RANGE`: read address, qualified by read.
- `wum__wuf__stall` out 1: registered backpressure to the fetcher.
- `sys__wum__write` in 1: system load strobe.
- `sys__wum__addr` in `MGR_WU_ADDRESS_RANGE`: load address.
- `sys__wum__wdata` in `WU_DATA_WIDTH`: load data.
- `wum__dec__valid` out 1: FIFO head valid.
- `wum__dec__data` out `WU_DATA_WIDTH`: FIFO head word.
- `dec__wum__ready` in 1: decoder accepts head.
- `wum__sys__err` out 2: sticky flags. Bit 0 is overflow. Bit 1 is read address out of range.

## Operation
- Array: 1 read port and 1 write port. A read registered at edge N presents its data at edge N+1, where it is pushed into the FIFO.
- Read and write to the same address in the same cycle: the read returns the old data.
- Address `>= WU_DEPTH`:
  - Reads return all-zero data and set err[1].
  - Writes are ignored and set err[1].
- `inflight` (0..1) counts the read issued last cycle but not yet pushed into the FIFO.
- FIFO push and pop in the same cycle: occupancy is unchanged. This also applies when the FIFO is full.
- Pop occurs on `wum__dec__valid && dec__wum__ready`.
- `wum__wuf__stall` next = `(count_next + inflight_next) >= FIFO_DEPTH - STALL_SKID`. `count_next` and `inflight_next` are this cycle's post-update values.
- Push into a full FIFO with no simultaneous pop: the word is dropped and err[0] is set. The FIFO contents are unchanged.
- Error flags clear only on reset.
- Reads arriving while stall is asserted are still serviced. The skid exists to absorb them.
- Order: returned words leave in request order. No reordering and no duplication.

## Timing
- Reset values:
  - `wum__wuf__stall`=0, `wum__dec__valid`=0, `wum__dec__data`=0, `wum__sys__err`=0.
  - FIFO pointers, count and inflight are cleared.
  - Array contents are not reset.
- Reset asserted mid-operation: any in-flight read is discarded and the FIFO empties on the next edge.
- Latency from read sampled to `wum__dec__valid`, with the FIFO empty: 2 edges (array read, then FIFO write). The data is on the head the same cycle valid rises.
- Stall reaction: the fetcher registers stall and its own outputs, so up to 3 further reads can arrive after stall rises. `STALL_SKID` must be >= 4, which covers those 3 plus the inflight read.
- Stall deasserts one edge after the occupancy condition falls below threshold.
- A write is visible to reads sampled on the following edge or later.

## Structure
- Shared header `wu_memory.vh` holds:
  - `WUM_FIFO_DEPTH`, `WUM_STALL_SKID`, `WUM_DATA_WIDTH`;
  - the err bit index defines `WUM_ERR_OVERFLOW` (0) and `WUM_ERR_ADDR` (1).
- `MGR_WU_ADDRESS_RANGE` stays in `manager.vh`.
- One sub-module `wu_mem_fifo`: synchronous FIFO with count output and push/pop/full/empty.
- The array is inferred in `wu_memory`, or replaced by an SRAM macro wrapper later.

## Test plan
- Load and stream:
  - Stimulus: write words 0..15 with data = 0x1000+addr; then read addresses 0..15 on consecutive cycles with ready=1.
  - Required: 16 valid beats, data 0x1000..0x100F in order; first valid 2 edges after the first read; stall never asserts.
- Backpressure skid:
  - Stimulus: ready=0; reads on every cycle, with the fetcher model honouring stall through a 2-register delay.
  - Required: stall rises when count+inflight reaches 4; FIFO reaches at most 8; err[0] stays 0.
- Overflow:
  - Stimulus: ready=0; the fetcher model ignores stall; 10 reads are issued.
  - Required: FIFO holds the first 8 words; err[0]=1 and stays set.
- Simultaneous push/pop while full:
  - Stimulus: FIFO full; ready=1 and a read on the same cycle.
  - Required: count stays 8; no drop; err[0]=0.
- Same-address read/write and out-of-range address:
  - Stimulus: write 0xAAAA to address 5 while reading address 5; then read address `WU_DEPTH`.
  - Required: the first read returns the old address-5 data; the next read of address 5 returns 0xAAAA; the out-of-range read returns 0 and sets err[1].
- Reset mid-stream:
  - Stimulus: assert reset with 5 words queued and 1 read in flight.
  - Required: the next edge gives valid=0, stall=0, err=0; after reset, reading address 0 returns the previously loaded data.

Source files
------------

// File: rtl/wu_memory_pkg.sv
// wu_memory_pkg
// Shared constants for the WU instruction store and its fetch responder:
// default FIFO/skid/data sizing, the error-flag bit positions, the manager
// WU address width, and a range-check helper used by both array ports.
package wu_memory_pkg;

    // Width of the manager WU address bus. Wide enough that WU_DEPTH itself
    // is representable, so out-of-range accesses can be detected.
    localparam int unsigned MGR_WU_ADDR_W  = 12;

    localparam int unsigned WUM_FIFO_DEPTH = 8;
    localparam int unsigned WUM_STALL_SKID = 4;
    localparam int unsigned WUM_DATA_WIDTH = 64;

    // Sticky error flag bit positions
    localparam int unsigned WUM_ERR_OVERFLOW = 0;
    localparam int unsigned WUM_ERR_ADDR     = 1;
    localparam int unsigned WUM_ERR_W        = 2;

    function automatic logic wum_addr_in_range(input logic [MGR_WU_ADDR_W-1:0] addr,
                                               input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/wu_mem_fifo.sv
// wu_mem_fifo
// Synchronous FIFO holding array read returns for the WU decoder.
// Ports:
//   clk, reset_poweron   - clock, synchronous active-high reset
//   push, push_data      - write request; ignored when full unless popping too
//   pop                  - remove head (ignored when empty)
//   pop_data             - current head word (meaningful when !empty)
//   full, empty, count   - occupancy status
module wu_mem_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (32'(count_q) == DEPTH);
        do_pop  = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push = push && (!full || do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        count    = count_q;
        pop_data = storage[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset_poweron) begin
            storage[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wu_memory.sv
// wu_memory
// Responder side of the WU fetch interface: WU instruction store with a
// system load port, a 1-cycle read path for the fetcher, and an output FIFO
// toward the WU decoder with early backpressure.
// Ports:
//   clk, reset_poweron                 - clock, synchronous active-high reset
//   wuf__wum__read/addr                - fetcher read request (one word/cycle)
//   wum__wuf__stall                    - registered backpressure to the fetcher
//   sys__wum__write/addr/wdata         - system load port
//   wum__dec__valid/data, dec__wum__ready - FIFO head toward the decoder
//   wum__sys__err                      - sticky {addr out of range, overflow}
module wu_memory
    import wu_memory_pkg::*;
#(
    parameter int unsigned WU_DATA_WIDTH = WUM_DATA_WIDTH,
    parameter int unsigned WU_DEPTH      = 1024,
    parameter int unsigned FIFO_DEPTH    = WUM_FIFO_DEPTH,
    // Must be >= 4: three reads from the fetcher's pipeline plus the inflight one.
    parameter int unsigned STALL_SKID    = WUM_STALL_SKID
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     wuf__wum__read,
    input  logic [MGR_WU_ADDR_W-1:0] wuf__wum__addr,
    output logic                     wum__wuf__stall,
    input  logic                     sys__wum__write,
    input  logic [MGR_WU_ADDR_W-1:0] sys__wum__addr,
    input  logic [WU_DATA_WIDTH-1:0] sys__wum__wdata,
    output logic                     wum__dec__valid,
    output logic [WU_DATA_WIDTH-1:0] wum__dec__data,
    input  logic                     dec__wum__ready,
    output logic [WUM_ERR_W-1:0]     wum__sys__err
);

    localparam int unsigned IdxW       = $clog2(WU_DEPTH);
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned StallLevel = FIFO_DEPTH - STALL_SKID;

    logic [WU_DATA_WIDTH-1:0] mem [WU_DEPTH];

    logic                     rd_in_range, wr_in_range;
    logic                     rd_valid_q;   // the single inflight read
    logic [WU_DATA_WIDTH-1:0] rd_data_q;

    logic                     fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]          fifo_count, count_next;
    logic [CntW:0]            occ_next;
    logic [WU_DATA_WIDTH-1:0] fifo_head;
    logic                     push_ok, overflow;

    logic                     stall_q, stall_d;
    logic [WUM_ERR_W-1:0]     err_q, err_d;

    always_comb begin
        rd_in_range = wum_addr_in_range(wuf__wum__addr, WU_DEPTH);
        wr_in_range = wum_addr_in_range(sys__wum__addr, WU_DEPTH);

        fifo_pop = !fifo_empty && dec__wum__ready;
        push_ok  = rd_valid_q && (!fifo_full || fifo_pop);
        overflow = rd_valid_q && fifo_full && !fifo_pop;

        count_next = fifo_count;
        if (push_ok && !fifo_pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push_ok && fifo_pop) begin
            count_next = fifo_count - 1'b1;
        end

        // Post-update occupancy plus the read sampled this cycle (next inflight).
        occ_next = {1'b0, count_next} + {{CntW{1'b0}}, wuf__wum__read};
        stall_d  = (32'(occ_next) >= StallLevel);

        err_d = err_q;
        if (overflow) err_d[WUM_ERR_OVERFLOW] = 1'b1;
        if ((wuf__wum__read && !rd_in_range) || (sys__wum__write && !wr_in_range)) begin
            err_d[WUM_ERR_ADDR] = 1'b1;
        end
    end

    // Array write port; out-of-range loads are dropped.
    always_ff @(posedge clk) begin
        if (sys__wum__write && wr_in_range) begin
            mem[sys__wum__addr[IdxW-1:0]] <= sys__wum__wdata;
        end
    end

    // Array read port; a same-cycle write to the same word is not seen (old data).
    always_ff @(posedge clk) begin
        if (wuf__wum__read) begin
            rd_data_q <= rd_in_range ? mem[wuf__wum__addr[IdxW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            rd_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            rd_valid_q <= wuf__wum__read;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    wu_mem_fifo #(
        .DATA_WIDTH (WU_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (rd_valid_q),
        .push_data     (rd_data_q),
        .pop           (fifo_pop),
        .pop_data      (fifo_head),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count)
    );

    always_comb begin
        wum__wuf__stall = stall_q;
        wum__dec__valid = !fifo_empty;
        wum__dec__data  = fifo_empty ? '0 : fifo_head;
        wum__sys__err   = err_q;
    end

endmodule

// File: tb/tb_wu_memory.sv
module tb_wu_memory;
    import wu_memory_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 1024;

    logic                     clk;
    logic                     reset_poweron;
    logic                     rd;
    logic [MGR_WU_ADDR_W-1:0] raddr;
    logic                     stall;
    logic                     wr;
    logic [MGR_WU_ADDR_W-1:0] waddr;
    logic [DW-1:0]            wdata;
    logic                     valid;
    logic [DW-1:0]            data;
    logic                     ready;
    logic [1:0]               err;

    int tests;
    int fails;

    wu_memory #(
        .WU_DATA_WIDTH (DW),
        .WU_DEPTH      (DEPTH),
        .FIFO_DEPTH    (8),
        .STALL_SKID    (4)
    ) dut (
        .clk             (clk),
        .reset_poweron   (reset_poweron),
        .wuf__wum__read  (rd),
        .wuf__wum__addr  (raddr),
        .wum__wuf__stall (stall),
        .sys__wum__write (wr),
        .sys__wum__addr  (waddr),
        .sys__wum__wdata (wdata),
        .wum__dec__valid (valid),
        .wum__dec__data  (data),
        .dec__wum__ready (ready),
        .wum__sys__err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic d1, d2;

    initial begin
        tests = 0;
        fails = 0;
        reset_poweron = 1'b1;
        rd = 1'b0; raddr = '0; wr = 1'b0; waddr = '0; wdata = '0; ready = 1'b0;
        step();
        step();
        reset_poweron = 1'b0;
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_data",  data,       64'd0);
        check("reset_err",   64'(err),   64'd0);

        // Load words 0..15 with 0x1000+addr
        for (int a = 0; a < 16; a++) begin
            wr = 1'b1; waddr = MGR_WU_ADDR_W'(a); wdata = 64'h1000 + 64'(a);
            step();
        end
        wr = 1'b0;

        // Stream 0..15 with ready held high
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1; raddr = MGR_WU_ADDR_W'(i);
            step();
            if (i == 0) begin
                check("stream_first_edge_valid", 64'(valid), 64'd0);
            end else begin
                check("stream_valid", 64'(valid), 64'd1);
                check("stream_data",  data, 64'h1000 + 64'(i - 1));
            end
            check("stream_stall", 64'(stall), 64'd0);
        end
        rd = 1'b0;
        step();
        check("stream_last_valid", 64'(valid), 64'd1);
        check("stream_last_data",  data, 64'h100F);
        step();
        check("stream_drained", 64'(valid), 64'd0);

        // Backpressure: fetcher honours stall through two registers
        ready = 1'b0; d1 = 1'b0; d2 = 1'b0; raddr = '0; rd = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (rd) raddr = raddr + 1'b1;
            if (n == 3) check("skid_stall_below", 64'(stall), 64'd0);
            if (n == 4) check("skid_stall_rise",  64'(stall), 64'd1);
            d2 = d1;
            d1 = stall;
            rd = !d2;
        end
        rd = 1'b0;
        check("skid_count",  64'(dut.u_fifo.count), 64'd5);
        check("skid_stall",  64'(stall), 64'd1);
        check("skid_err",    64'(err),   64'd0);
        ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("skid_drain_valid", 64'(valid), 64'd1);
            check("skid_drain_data",  data, 64'h1000 + 64'(j));
            step();
            if (j == 0) check("skid_stall_hold", 64'(stall), 64'd1);
            if (j == 1) check("skid_stall_fall", 64'(stall), 64'd0);
        end
        check("skid_empty", 64'(valid), 64'd0);
        ready = 1'b0;

        // Overflow: 10 reads, stall ignored
        for (int i = 0; i < 10; i++) begin
            rd = 1'b1; raddr = MGR_WU_ADDR_W'(i);
            step();
        end
        rd = 1'b0;
        step();
        step();
        check("ovf_count", 64'(dut.u_fifo.count), 64'd8);
        check("ovf_err",   64'(err), 64'd1);
        check("ovf_stall", 64'(stall), 64'd1);
        ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("ovf_drain_data", data, 64'h1000 + 64'(j));
            step();
        end
        check("ovf_empty",      64'(valid), 64'd0);
        check("ovf_err_sticky", 64'(err),   64'd1);
        ready = 1'b0;

        // Simultaneous push and pop while full
        reset_poweron = 1'b1;
        step();
        reset_poweron = 1'b0;
        check("full_pp_err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < 9; i++) begin
            rd = 1'b1; raddr = MGR_WU_ADDR_W'(i);
            step();
        end
        rd = 1'b0; ready = 1'b1;
        step();
        ready = 1'b0;
        check("full_pp_count", 64'(dut.u_fifo.count), 64'd8);
        check("full_pp_err",   64'(err), 64'd0);
        check("full_pp_head",  data, 64'h1001);
        ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("full_pp_drain", data, 64'h1001 + 64'(j));
            step();
        end
        check("full_pp_empty", 64'(valid), 64'd0);

        // Same-address read/write, then out-of-range read
        wr = 1'b1; waddr = 5; wdata = 64'hAAAA;
        rd = 1'b1; raddr = 5;
        step();
        wr = 1'b0;
        step();
        check("rw_old_valid", 64'(valid), 64'd1);
        check("rw_old_data",  data, 64'h1005);
        check("rw_err_clear", 64'(err), 64'd0);
        raddr = MGR_WU_ADDR_W'(DEPTH);
        step();
        rd = 1'b0;
        check("rw_new_data", data, 64'hAAAA);
        check("oor_err",     64'(err), 64'd2);
        step();
        check("oor_valid", 64'(valid), 64'd1);
        check("oor_data",  data, 64'd0);
        step();
        check("oor_empty", 64'(valid), 64'd0);

        // Reset with 5 queued and 1 inflight
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd = 1'b1; raddr = MGR_WU_ADDR_W'(i);
            step();
        end
        rd = 1'b0;
        check("mid_count",     64'(dut.u_fifo.count), 64'd5);
        check("mid_stall_pre", 64'(stall), 64'd1);
        reset_poweron = 1'b1;
        step();
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        check("mid_rst_err",   64'(err),   64'd0);
        check("mid_rst_data",  data,       64'd0);
        reset_poweron = 1'b0;
        step();
        step();
        check("mid_inflight_dropped", 64'(valid), 64'd0);
        ready = 1'b1; rd = 1'b1; raddr = 0;
        step();
        rd = 1'b0;
        check("post_rst_lat", 64'(valid), 64'd0);
        step();
        check("post_rst_valid", 64'(valid), 64'd1);
        check("post_rst_data",  data, 64'h1000);
        step();
        check("post_rst_empty", 64'(valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
